// File: rtl/sm83_ir_decode.sv
// sm83_ir_decode: instruction register and opcode decoder; optional CB page via SM83_CB_PREFIX_EN
package sm83_pkg;
  typedef enum logic [2:0] {
    CTL_NOP, CTL_HALT, CTL_LD_R8_R8, CTL_LDPTR_R8_HL,
    CTL_LDPTR_HL_R8, CTL_LD_R8_D8, CTL_LDPTR_HL_D8, CTL_ALU_R8
  } ctl_op_t;
  typedef enum logic [4:0] {
    ALU_LD = 5'd0, ALU_ADD, ALU_ADC, ALU_SUB, ALU_SBC, ALU_AND, ALU_XOR, ALU_OR, ALU_CP
`ifdef SM83_CB_PREFIX_EN
    , ALU_RLC, ALU_RRC, ALU_RL, ALU_RR, ALU_SLA, ALU_SRA, ALU_SWAP, ALU_SRL,
    ALU_BIT, ALU_RES, ALU_SET
`endif
  } alu_op_t;
  typedef struct packed {
    ctl_op_t    ctl;
    alu_op_t    alu;
    logic [2:0] dst;
    logic [2:0] src;
    logic [2:0] bidx;
    logic       unsup;
  } dec_t;
endpackage

module sm83_ir_decode
  import sm83_pkg::*;
#(
  parameter int         CNT_W  = 8,
  parameter logic [7:0] RST_IR = 8'h00
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mem_to_ir,
  input  logic [7:0]       mem_rdata,
  input  logic             halt,
  output logic [7:0]       ir,
  output ctl_op_t          ctl_op,
  output alu_op_t          decoded_alu_op,
  output logic [2:0]       r8_dst_sel,
  output logic [2:0]       r8_src_sel,
  output logic [2:0]       bit_idx,
  output logic             unsupported,
  output logic [CNT_W-1:0] unsupported_cnt
);
  function automatic dec_t decode(input logic [7:0] op, input logic cb);
    dec_t d;
    d = '{ctl: CTL_NOP, alu: ALU_LD, dst: 3'd0, src: 3'd0, bidx: 3'd0, unsup: 1'b1};
    if (cb) begin
`ifdef SM83_CB_PREFIX_EN
      if (op[2:0] != 3'b110) begin
        d.ctl   = CTL_ALU_R8;
        d.dst   = op[2:0];
        d.src   = op[2:0];
        d.unsup = 1'b0;
        d.alu   = op[7:6] == 2'b00 ? alu_op_t'(5'd9 + 5'(op[5:3])) : alu_op_t'(5'd16 + 5'(op[7:6]));
        d.bidx  = op[7:6] == 2'b00 ? 3'd0 : op[5:3];
      end
`endif
    end else if (op == 8'h00) begin
      d.unsup = 1'b0;
    end else if (op == 8'h76) begin
      d.ctl   = CTL_HALT;
      d.unsup = 1'b0;
    end else if (op[7:6] == 2'b01) begin
      d.ctl   = op[2:0] == 3'b110 ? CTL_LDPTR_R8_HL : op[5:3] == 3'b110 ? CTL_LDPTR_HL_R8 : CTL_LD_R8_R8;
      d.dst   = op[5:3];
      d.src   = op[2:0];
      d.unsup = 1'b0;
    end else if (op[7:6] == 2'b00 && op[2:0] == 3'b110) begin
      d.ctl   = op[5:3] == 3'b110 ? CTL_LDPTR_HL_D8 : CTL_LD_R8_D8;
      d.dst   = op[5:3];
      d.unsup = 1'b0;
    end else if (op[7:6] == 2'b10 && op[2:0] != 3'b110) begin
      d.ctl   = CTL_ALU_R8;
      d.alu   = alu_op_t'(5'(op[5:3]) + 5'd1);
      d.dst   = 3'b111;
      d.src   = op[2:0];
      d.unsup = 1'b0;
`ifdef SM83_CB_PREFIX_EN
    end else if (op == 8'hCB) begin
      d.unsup = 1'b0;
`endif
    end
    return d;
  endfunction

  logic [7:0]       ir_q;
  logic [CNT_W-1:0] cnt_q;
  logic             cb_q, cb_d, load;
  dec_t             cur, nxt;

  assign load = mem_to_ir && !halt;
`ifdef SM83_CB_PREFIX_EN
  // A prefix byte only arms the CB page when it was itself fetched unprefixed.
  assign cb_d = ir_q == 8'hCB && !cb_q;
  always_ff @(posedge clk)
    if (rst) cb_q <= 1'b0;
    else if (load) cb_q <= cb_d;
`else
  assign cb_q = 1'b0;
  assign cb_d = 1'b0;
`endif

  // The incoming byte is judged with the prefix state it will be decoded under.
  assign cur = decode(ir_q, cb_q);
  assign nxt = decode(mem_rdata, cb_d);

  always_ff @(posedge clk)
    if (rst) begin
      ir_q  <= RST_IR;
      cnt_q <= '0;
    end else if (load) begin
      ir_q <= mem_rdata;
      if (nxt.unsup && cnt_q != '1) cnt_q <= cnt_q + CNT_W'(1);
    end

  assign ir              = ir_q;
  assign ctl_op          = cur.ctl;
  assign decoded_alu_op  = cur.alu;
  assign r8_dst_sel      = cur.dst;
  assign r8_src_sel      = cur.src;
  assign bit_idx         = cur.bidx;
  assign unsupported     = cur.unsup;
  assign unsupported_cnt = cnt_q;
endmodule

// File: tb/tb_sm83_ir_decode.sv
// tb_sm83_ir_decode: directed checks of IR load, decode, halt freeze, prefix and counter
module tb_sm83_ir_decode;
  import sm83_pkg::*;
  logic       clk = 1'b0, rst = 1'b0, mem_to_ir = 1'b0, halt = 1'b0;
  logic [7:0] mem_rdata = 8'h00, ir;
  ctl_op_t    ctl_op;
  alu_op_t    decoded_alu_op;
  logic [2:0] r8_dst_sel, r8_src_sel, bit_idx;
  logic       unsupported;
  logic [7:0] unsupported_cnt;
  int         checks = 0, failures = 0, exp_cnt = 0;

  sm83_ir_decode #(.CNT_W(8), .RST_IR(8'h00)) dut (
    .clk(clk), .rst(rst), .mem_to_ir(mem_to_ir), .mem_rdata(mem_rdata), .halt(halt),
    .ir(ir), .ctl_op(ctl_op), .decoded_alu_op(decoded_alu_op), .r8_dst_sel(r8_dst_sel),
    .r8_src_sel(r8_src_sel), .bit_idx(bit_idx), .unsupported(unsupported),
    .unsupported_cnt(unsupported_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic load(input logic [7:0] b);
    @(negedge clk);
    mem_rdata = b;
    mem_to_ir = 1'b1;
    @(negedge clk);
    mem_to_ir = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_ir", 32'(ir), 32'h00);
    chk("rst_ctl", 32'(ctl_op), 32'(CTL_NOP));
    chk("rst_cnt", 32'(unsupported_cnt), 0);
    chk("rst_unsup", 32'(unsupported), 0);
    chk("rst_sel", 32'({r8_dst_sel, r8_src_sel, bit_idx}), 0);

    load(8'h41);
    chk("41_ctl", 32'(ctl_op), 32'(CTL_LD_R8_R8));
    chk("41_dst", 32'(r8_dst_sel), 0);
    chk("41_src", 32'(r8_src_sel), 1);
    chk("41_alu", 32'(decoded_alu_op), 32'(ALU_LD));
    load(8'h7E);
    chk("7e_ctl", 32'(ctl_op), 32'(CTL_LDPTR_R8_HL));
    chk("7e_dst", 32'(r8_dst_sel), 7);
    load(8'h70);
    chk("70_ctl", 32'(ctl_op), 32'(CTL_LDPTR_HL_R8));
    chk("70_src", 32'(r8_src_sel), 0);
    load(8'h91);
    chk("91_ctl", 32'(ctl_op), 32'(CTL_ALU_R8));
    chk("91_alu", 32'(decoded_alu_op), 32'(ALU_SUB));
    chk("91_sel", 32'({r8_dst_sel, r8_src_sel}), 32'({3'd7, 3'd1}));
    load(8'hBB);
    chk("bb_alu", 32'(decoded_alu_op), 32'(ALU_CP));
    chk("bb_src", 32'(r8_src_sel), 3);
    load(8'h86);
    exp_cnt++;
    chk("86_ctl", 32'(ctl_op), 32'(CTL_NOP));
    chk("86_unsup", 32'(unsupported), 1);
    chk("86_cnt", 32'(unsupported_cnt), 32'(exp_cnt));
    load(8'h36);
    chk("36_ctl", 32'(ctl_op), 32'(CTL_LDPTR_HL_D8));
    load(8'h3E);
    chk("3e_ctl", 32'(ctl_op), 32'(CTL_LD_R8_D8));
    chk("3e_dst", 32'(r8_dst_sel), 7);

    load(8'h76);
    chk("76_ctl", 32'(ctl_op), 32'(CTL_HALT));
    @(negedge clk);
    halt = 1'b1;
    mem_to_ir = 1'b1;
    mem_rdata = 8'hD3;
    repeat (2) @(negedge clk);
    chk("halt_ir", 32'(ir), 32'h76);
    chk("halt_ctl", 32'(ctl_op), 32'(CTL_HALT));
    chk("halt_cnt", 32'(unsupported_cnt), 32'(exp_cnt));
    halt = 1'b0;
    mem_to_ir = 1'b0;

`ifdef SM83_CB_PREFIX_EN
    load(8'hCB);
    chk("cb_ctl", 32'(ctl_op), 32'(CTL_NOP));
    chk("cb_unsup", 32'(unsupported), 0);
    load(8'h7A);
    chk("7a_ctl", 32'(ctl_op), 32'(CTL_ALU_R8));
    chk("7a_alu", 32'(decoded_alu_op), 32'(ALU_BIT));
    chk("7a_bit", 32'(bit_idx), 7);
    chk("7a_sel", 32'({r8_dst_sel, r8_src_sel}), 32'({3'd2, 3'd2}));
    load(8'hCB);
    load(8'h06);
    chk("cb06_unsup", 32'(unsupported), 1);
    exp_cnt++;
    chk("cb06_cnt", 32'(unsupported_cnt), 32'(exp_cnt));
    load(8'hCB);
    load(8'h1D);
    chk("1d_alu", 32'(decoded_alu_op), 32'(ALU_RR));
    chk("1d_bit", 32'(bit_idx), 0);
    load(8'hCB);
    load(8'hCB);
    chk("cbcb_ctl", 32'(ctl_op), 32'(CTL_ALU_R8));
    chk("cbcb_alu", 32'(decoded_alu_op), 32'(ALU_SET));
    chk("cbcb_bit", 32'(bit_idx), 1);
    chk("cbcb_src", 32'(r8_src_sel), 3);
    load(8'h00);
    chk("cbcb00_ctl", 32'(ctl_op), 32'(CTL_NOP));
    chk("cbcb00_unsup", 32'(unsupported), 0);
`else
    load(8'hCB);
    exp_cnt++;
    chk("cb_ctl", 32'(ctl_op), 32'(CTL_NOP));
    chk("cb_unsup", 32'(unsupported), 1);
    chk("cb_cnt", 32'(unsupported_cnt), 32'(exp_cnt));
    load(8'h7A);
    chk("7a_ctl", 32'(ctl_op), 32'(CTL_LD_R8_R8));
    chk("7a_bit", 32'(bit_idx), 0);
`endif

    @(negedge clk);
    mem_rdata = 8'hD3;
    mem_to_ir = 1'b1;
    repeat (100) @(negedge clk);
    chk("cnt_mid", 32'(unsupported_cnt), 32'(exp_cnt + 100));
    repeat (200) @(negedge clk);
    chk("cnt_sat", 32'(unsupported_cnt), 255);
    chk("d3_unsup", 32'(unsupported), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("mrst_cnt", 32'(unsupported_cnt), 0);
    chk("mrst_ir", 32'(ir), 32'h00);
    chk("mrst_ctl", 32'(ctl_op), 32'(CTL_NOP));
    rst = 1'b0;
    mem_to_ir = 1'b0;
    load(8'h41);
    chk("post_ctl", 32'(ctl_op), 32'(CTL_LD_R8_R8));
    chk("post_cnt", 32'(unsupported_cnt), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
